// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: valid/ready handshake, NOP bubbles, flush,
// optional skid entry for a registered in_ready, saturating stall counter.
module if_id_stage_reg #(
   parameter int unsigned        INSTR_W   = 32,
   parameter int unsigned        PC_W      = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013),
   parameter bit                 SKID_EN   = 1'b1,
   parameter int unsigned        CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               clr_stats,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instruction,
   input  logic [PC_W-1:0]    in_pc_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] instruction,
   output logic [PC_W-1:0]    pc_data,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   stall_count
);

   logic               in_fire;
   logic               advance;
   logic               skid_valid;
   logic [INSTR_W-1:0] skid_instr;
   logic [PC_W-1:0]    skid_pc;

   assign in_fire   = in_valid && in_ready;
   assign advance   = !out_valid || out_ready;
   assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid   <= 1'b0;
         instruction <= NOP_INSTR;
         pc_data     <= '0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         instruction <= NOP_INSTR;
         pc_data     <= '0;
      end else if (advance) begin
         if (skid_valid) begin
            out_valid   <= 1'b1;
            instruction <= skid_instr;
            pc_data     <= skid_pc;
         end else if (in_fire) begin
            out_valid   <= 1'b1;
            instruction <= in_instruction;
            pc_data     <= in_pc_data;
         end else begin
            out_valid   <= 1'b0;
            instruction <= NOP_INSTR;
         end
      end
   end

   generate
      if (SKID_EN) begin : g_skid
         // The skid entry only fills while main is stalled, so in_ready
         // can come straight from a flop.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               skid_valid <= 1'b0;
               skid_instr <= NOP_INSTR;
               skid_pc    <= '0;
            end else if (flush) begin
               skid_valid <= 1'b0;
            end else if (skid_valid && advance) begin
               skid_valid <= 1'b0;
            end else if (!advance && in_fire) begin
               skid_valid <= 1'b1;
               skid_instr <= in_instruction;
               skid_pc    <= in_pc_data;
            end
         end

         assign in_ready = !skid_valid;
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign skid_instr = NOP_INSTR;
         assign skid_pc    = '0;
         assign in_ready   = advance;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
      end else if (clr_stats) begin
         stall_count <= '0;
      end else if (out_valid && !out_ready &&
                   stall_count != {CNT_W{1'b1}}) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed bench for if_id_stage_reg: default skid instance plus a
// no-skid instance with a 4-bit stall counter.
module tb_if_id_stage_reg;

   logic        clk;
   logic        reset_n;

   logic        a_flush, a_clr, a_in_valid, a_in_ready;
   logic [31:0] a_in_instr, a_in_pc;
   logic        a_out_valid, a_out_ready;
   logic [31:0] a_instr, a_pc;
   logic [1:0]  a_occ;
   logic [15:0] a_stall;

   logic        b_flush, b_clr, b_in_valid, b_in_ready;
   logic [31:0] b_in_instr, b_in_pc;
   logic        b_out_valid, b_out_ready;
   logic [31:0] b_instr, b_pc;
   logic [1:0]  b_occ;
   logic [3:0]  b_stall;

   int n_chk;
   int n_err;

   if_id_stage_reg dut_a (
      .clk            (clk),
      .reset_n        (reset_n),
      .flush          (a_flush),
      .clr_stats      (a_clr),
      .in_valid       (a_in_valid),
      .in_ready       (a_in_ready),
      .in_instruction (a_in_instr),
      .in_pc_data     (a_in_pc),
      .out_valid      (a_out_valid),
      .out_ready      (a_out_ready),
      .instruction    (a_instr),
      .pc_data        (a_pc),
      .occupancy      (a_occ),
      .stall_count    (a_stall)
   );

   if_id_stage_reg #(
      .SKID_EN (1'b0),
      .CNT_W   (4)
   ) dut_b (
      .clk            (clk),
      .reset_n        (reset_n),
      .flush          (b_flush),
      .clr_stats      (b_clr),
      .in_valid       (b_in_valid),
      .in_ready       (b_in_ready),
      .in_instruction (b_in_instr),
      .in_pc_data     (b_in_pc),
      .out_valid      (b_out_valid),
      .out_ready      (b_out_ready),
      .instruction    (b_instr),
      .pc_data        (b_pc),
      .occupancy      (b_occ),
      .stall_count    (b_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_push(input logic [31:0] pc);
      a_in_valid = 1'b1;
      a_in_pc    = pc;
      a_in_instr = 32'hAA00_0000 | pc;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      reset_n = 1'b0;
      {a_flush, a_clr, a_in_valid, a_out_ready} = '0;
      {b_flush, b_clr, b_in_valid, b_out_ready} = '0;
      a_in_instr = '0; a_in_pc = '0;
      b_in_instr = '0; b_in_pc = '0;
      tick(); tick();

      chk("rst_valid", a_out_valid, 0);
      chk("rst_instr", a_instr, 32'h13);
      chk("rst_pc", a_pc, 0);
      chk("rst_ready", a_in_ready, 1);
      chk("rst_occ", a_occ, 0);
      chk("rst_stall", a_stall, 0);
      reset_n = 1'b1;
      tick();

      // single transfer, then empty stage for 3 cycles
      a_in_valid = 1'b1;
      a_in_instr = 32'h00A0_0093;
      a_in_pc    = 32'h100;
      a_out_ready = 1'b1;
      tick();
      chk("xfer_valid", a_out_valid, 1);
      chk("xfer_instr", a_instr, 32'h00A0_0093);
      chk("xfer_pc", a_pc, 32'h100);
      chk("xfer_occ", a_occ, 1);
      a_in_valid = 1'b0;
      tick(); tick(); tick();
      chk("empty_valid", a_out_valid, 0);
      chk("empty_instr", a_instr, 32'h13);
      chk("empty_pc_hold", a_pc, 32'h100);
      chk("empty_occ", a_occ, 0);

      // back-pressure into the skid entry
      a_out_ready = 1'b0;
      a_push(32'h100);
      tick();
      chk("bp1_pc", a_pc, 32'h100);
      chk("bp1_ready", a_in_ready, 1);
      a_push(32'h104);
      tick();
      chk("bp2_ready", a_in_ready, 0);
      chk("bp2_occ", a_occ, 2);
      chk("bp2_pc", a_pc, 32'h100);
      a_push(32'h108);
      tick();
      chk("bp3_occ", a_occ, 2);
      chk("bp3_pc", a_pc, 32'h100);
      chk("bp3_instr", a_instr, 32'hAA00_0100);
      chk("bp3_stall", a_stall, 2);
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      tick();
      chk("drain1_pc", a_pc, 32'h104);
      chk("drain1_instr", a_instr, 32'hAA00_0104);
      chk("drain1_occ", a_occ, 1);
      chk("drain1_ready", a_in_ready, 1);
      chk("drain1_stall", a_stall, 2);
      tick();
      chk("drain2_valid", a_out_valid, 0);
      chk("drain2_occ", a_occ, 0);

      // flush with both entries held
      a_out_ready = 1'b0;
      a_push(32'h200);
      tick();
      a_push(32'h204);
      tick();
      chk("fl_pre_occ", a_occ, 2);
      a_push(32'h208);
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      a_in_valid = 1'b0;
      chk("fl_valid", a_out_valid, 0);
      chk("fl_instr", a_instr, 32'h13);
      chk("fl_pc", a_pc, 0);
      chk("fl_occ", a_occ, 0);
      chk("fl_ready", a_in_ready, 1);
      chk("fl_stall", a_stall, 4);
      tick();
      chk("fl_after_valid", a_out_valid, 0);

      // flush discards a simultaneous in_fire
      a_push(32'h300);
      tick();
      a_push(32'h304);
      a_flush = 1'b1;
      tick();
      a_flush = 1'b0;
      a_in_valid = 1'b0;
      chk("fl2_occ", a_occ, 0);
      tick();
      chk("fl2_after_valid", a_out_valid, 0);
      chk("fl2_after_occ", a_occ, 0);
      chk("fl2_stall", a_stall, 5);
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      chk("clr_a", a_stall, 0);

      // asynchronous reset with both entries held
      a_push(32'h400);
      tick();
      a_push(32'h404);
      tick();
      a_in_valid = 1'b0;
      chk("ar_pre_occ", a_occ, 2);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_occ", a_occ, 0);
      chk("ar_valid", a_out_valid, 0);
      chk("ar_ready", a_in_ready, 1);
      chk("ar_instr", a_instr, 32'h13);
      chk("ar_stall", a_stall, 0);
      tick();
      reset_n = 1'b1;
      tick();

      // no-skid instance: combinational in_ready, 4-bit saturation
      b_out_ready = 1'b0;
      b_in_valid = 1'b1;
      b_in_pc = 32'h400;
      b_in_instr = 32'hBB00_0400;
      tick();
      chk("b_valid", b_out_valid, 1);
      chk("b_ready_comb", b_in_ready, 0);
      chk("b_occ", b_occ, 1);
      b_in_pc = 32'h404;
      b_in_instr = 32'hBB00_0404;
      for (int i = 0; i < 20; i++) tick();
      chk("b_sat", b_stall, 15);
      chk("b_hold_pc", b_pc, 32'h400);
      chk("b_hold_instr", b_instr, 32'hBB00_0400);
      b_clr = 1'b1;
      tick();
      b_clr = 1'b0;
      chk("b_clr", b_stall, 0);
      tick(); tick();
      chk("b_recount", b_stall, 2);
      b_clr = 1'b1;
      tick();
      b_clr = 1'b0;
      chk("b_clr_wins", b_stall, 0);

      b_out_ready = 1'b1;
      #1;
      chk("b_ready_up", b_in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         b_in_pc = 32'h500 + 32'(4 * i);
         b_in_instr = 32'hCC00_0500 + 32'(4 * i);
         tick();
         chk("b_pass_pc", b_pc, 32'h500 + 32'(4 * i));
         chk("b_pass_instr", b_instr, 32'hCC00_0500 + 32'(4 * i));
         chk("b_pass_occ", b_occ, 1);
      end
      b_in_valid = 1'b0;
      tick();
      chk("b_empty_valid", b_out_valid, 0);
      chk("b_empty_instr", b_instr, 32'h13);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
